// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared definitions for the instruction-fetch stage:
//     - instruction / PC constants (bubble encoding, PC increment, reset PC)
//     - the IF/ID pipeline bundle (instruction, pcplus4, valid)
//     - the IF/ID register operation (load / hold / bubble)
//     - a word-alignment helper for redirect targets
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // sll $0,$0,0 -- architecturally a no-op, used as the bubble encoding.
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // IF/ID pipeline register contents as seen by decode.
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  // What the IF/ID register does on the next rising edge.
  typedef enum logic [1:0] {
    IF_ID_LOAD   = 2'b00,
    IF_ID_HOLD   = 2'b01,
    IF_ID_BUBBLE = 2'b10
  } if_id_op_t;

  localparam if_id_t IF_ID_EMPTY = '{
    instruction: NOP_INSTR,
    pcplus4:     '0,
    valid:       1'b0
  };

  // Instructions are word aligned; the two low address bits of a redirect
  // target carry no meaning and are forced to zero.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage : fetch_pkg

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Each rising edge it either loads the freshly
//   fetched bundle, holds its contents, or is replaced by a bubble. An
//   asynchronous active-high reset empties it (bubble) immediately.
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   op    in   load / hold / bubble select for the next edge
//   d     in   bundle to capture when op == IF_ID_LOAD
//   q     out  registered bundle presented to decode
// -----------------------------------------------------------------------------
module if_id_reg
  import fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  if_id_op_t op,
  input  if_id_t    d,
  output if_id_t    q
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IF_ID_EMPTY;
    end else begin
      unique case (op)
        IF_ID_LOAD:   q <= d;
        IF_ID_BUBBLE: q <= IF_ID_EMPTY;
        default:      q <= q;
      endcase
    end
  end

endmodule : if_id_reg

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the pipelined MIPS datapath. Owns the program
//   counter, drives the instruction-memory address and captures the fetched
//   instruction into the IF/ID register. Hazard/branch control steers it with
//   Stall, Flush and Redirect so decode only ever sees a real instruction or
//   a NOP bubble. All outputs are registered.
//
// Parameters
//   RESET_PC           PC loaded on reset (address of the first instruction)
//
// Ports
//   Clk                in   rising-edge clock
//   Reset              in   asynchronous, active-high reset
//   Stall              in   hold PC and IF/ID (load-use hazard)
//   Flush              in   replace IF/ID contents with a bubble
//   Redirect           in   taken branch/jump resolved downstream
//   RedirectTarget     in   new PC when Redirect=1 (low two bits ignored)
//   IMemAddress        out  current PC, drives instruction memory
//   IMemData           in   combinational instruction read at IMemAddress
//   IF_ID_Instruction  out  registered instruction to decode
//   IF_ID_PCPlus4      out  registered PC+4 of that instruction
//   IF_ID_Valid        out  1 = real instruction, 0 = bubble
//   InstrCount         out  number of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemData,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] InstrCount
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr_count;
  if_id_op_t   if_id_op;
  if_id_t      if_id_d;
  if_id_t      if_id_q;

  // 32-bit unsigned add, carry dropped: 0xFFFFFFFC + 4 wraps to 0.
  assign pc_plus4 = pc + PC_INCR;

  // Next-PC and IF/ID control. Redirect outranks Stall for the PC (the
  // stalled instruction is on the wrong path anyway), and a Flush or
  // Redirect outranks Stall for IF/ID so the wrong-path slot is squashed.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would infer a latch.
    pc_next  = pc_plus4;
    if_id_op = IF_ID_LOAD;

    if (Redirect) begin
      pc_next = word_align(RedirectTarget);
    end else if (Stall) begin
      pc_next = pc;
    end

    if (Flush || Redirect) begin
      if_id_op = IF_ID_BUBBLE;
    end else if (Stall) begin
      if_id_op = IF_ID_HOLD;
    end
  end

  // The bundle captured on a load: the word read at the current PC, tagged
  // with the address of its sequential successor.
  always_comb begin
    if_id_d             = IF_ID_EMPTY;
    if_id_d.instruction = IMemData;
    if_id_d.pcplus4     = pc_plus4;
    if_id_d.valid       = 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Counts only real instructions entering decode; bubbles and held slots
  // are not counted. Wraps naturally at 2^32.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      instr_count <= '0;
    end else if (if_id_op == IF_ID_LOAD) begin
      instr_count <= instr_count + 32'd1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk (Clk),
    .rst (Reset),
    .op  (if_id_op),
    .d   (if_id_d),
    .q   (if_id_q)
  );

  assign IMemAddress       = pc;
  assign IF_ID_Instruction = if_id_q.instruction;
  assign IF_ID_PCPlus4     = if_id_q.pcplus4;
  assign IF_ID_Valid       = if_id_q.valid;
  assign InstrCount        = instr_count;

endmodule : fetch_stage

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS datapath: owns the program counter, drives the instruction-memory address, and captures the fetched instruction into the IF/ID pipeline register. It sits between the hazard/branch control (Stall, Flush, Redirect) and the decode stage. It applies stall, flush and branch/jump redirect so the downstream register file and controller always see either a valid instruction or a NOP bubble.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset (first instruction address)
- NOP_INSTR, 32'h00000000, bubble encoding (sll $0,$0,0)

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  hold PC and IF/ID contents (load-use hazard)
- Flush  in  1  replace IF/ID contents with a bubble
- Redirect  in  1  taken branch/jump resolved downstream
- RedirectTarget  in  32  new PC when Redirect=1
- IMemAddress  out  32  current PC, registered, drives instruction memory
- IMemData  in  32  combinational instruction read at IMemAddress
- IF_ID_Instruction  out  32  registered instruction to decode
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction
- IF_ID_Valid  out  1  1 = real instruction, 0 = bubble
- InstrCount  out  32  count of valid instructions loaded into IF/ID

## Operation
- Reset asserted (any time, including mid-operation): PC=RESET_PC, IF_ID_Instruction=NOP_INSTR, IF_ID_PCPlus4=0, IF_ID_Valid=0, InstrCount=0, immediately and held while Reset=1.
- PC update, per rising edge, priority order:
  - Redirect=1 -> PC <= {RedirectTarget[31:2],2'b00}. Low bits are ignored. Redirect wins over Stall.
  - else Stall=1 -> PC holds.
  - else PC <= PC+4, modulo 2^32. 0xFFFFFFFC wraps to 0x00000000.
- IF/ID update, per rising edge, priority order:
  - Flush=1 or Redirect=1 -> bubble: Instruction=NOP_INSTR, PCPlus4=0, Valid=0. Flush wins over Stall.
  - else Stall=1 -> all IF/ID fields hold.
  - else Instruction <= IMemData, PCPlus4 <= PC+4, Valid <= 1.
- InstrCount increments by 1 on exactly the edges where the IF/ID "load" branch is taken. It wraps at 2^32. It holds on stall and bubble.
- Flush without Redirect: PC still advances per the rules above. The flushed slot is lost and is not re-fetched.
- Stall+Flush with Redirect=0: PC holds and IF/ID is bubbled.
- The PC+4 adder is a 32-bit unsigned add with carry discarded.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- Fetch latency is 1 cycle: the instruction at IMemAddress during cycle n appears on IF_ID_Instruction after edge n.
- Redirect asserted in cycle n:
  - IMemAddress = target after edge n.
  - Target instruction in IF/ID after edge n+1.
  - IF/ID carries a bubble during cycle n+1.
- Stall is honoured on the same edge it is sampled. Release resumes with no lost or duplicated instruction.
- After Reset deasserts: IMemAddress = RESET_PC. The first edge loads the instruction at RESET_PC with Valid=1.
- IMemData must settle within one cycle of IMemAddress changing.

## Structure
- Shared package fetch_pkg holds:
  - constants NOP_INSTR, PC_INCR (=4) and the default RESET_PC;
  - the IF/ID bundle fields: instruction, pcplus4, valid.
- One sub-module, if_id_reg: the IF/ID register with load/hold/bubble control and async reset.
- The top level contains the PC register, the next-PC priority mux, the adder and InstrCount.

## Test plan
- Reset, then 4 free-running cycles with IMem[i]=0x1000+i:
  - IMemAddress goes 0,4,8,12.
  - IF/ID shows 0x1000..0x1003 with PCPlus4 4,8,12,16, Valid=1.
  - InstrCount=4.
- Stall for 2 cycles at PC=8:
  - IMemAddress stays 8 and IF/ID holds the instruction from PC=4.
  - InstrCount does not move.
  - On release, the instruction at 8 loads once.
- Redirect=1, RedirectTarget=0x00000043 at PC=0x10:
  - Next IMemAddress=0x40 and IF/ID is a bubble (Valid=0, NOP).
  - The following edge loads IMem[0x40] with PCPlus4=0x44.
- Stall=1 and Redirect=1 in the same cycle: PC takes the target and IF/ID is bubbled. Stall=1 and Flush=1: PC holds and IF/ID is bubbled.
- PC=0xFFFFFFFC, no stall: the next IMemAddress is 0x00000000 and IF_ID_PCPlus4=0x00000000.
- Reset asserted asynchronously mid-stream between edges: all outputs take their reset values immediately, without waiting for a clock edge.
